oh_fifo_rd_stream: RTL and testbench

- Read-side consumer for the generic dual-clock FIFO. Runs entirely in the FIFO read clock domain.
- Converts the FIFO's empty/rd_en/registered-dout interface, which has one cycle of read latency, into a valid/ready stream.
- A 3-entry skid buffer sustains one word per cycle with no combinational path from out_ready to fifo_rd_en.
- Sits between the FIFO read port and any downstream consumer (packet parser, bus master).

---
 rtl/oh_fifo_rd_stream_if.sv | 26 ++
 rtl/oh_fifo_rd_stream.sv | 114 +++++++++++
 tb/tb_oh_fifo_rd_stream.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/oh_fifo_rd_stream_if.sv
// Stream-side and FIFO-side signals of oh_fifo_rd_stream, bundled as one
// interface. The slave modport is the consumer block; the master modport is
// the surrounding system (FIFO read port plus downstream sink).
interface oh_fifo_rd_stream_if #(
  parameter int DW = 104
);
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_count;
  logic          busy;

  modport slave (
    input  fifo_empty, fifo_dout, clear, out_ready,
    output fifo_rd_en, out_valid, out_data, out_count, busy
  );

  modport master (
    output fifo_empty, fifo_dout, clear, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_count, busy
  );
endinterface

// File: rtl/oh_fifo_rd_stream.sv
// oh_fifo_rd_stream: read-side consumer for the dual-clock FIFO.
// Turns the FIFO's empty/rd_en/registered-dout port (one cycle read latency)
// into a valid/ready stream through a 3-entry skid buffer. fifo_rd_en depends
// only on registered state, fifo_empty and clear, never on out_ready.
// Optional statistics outputs are enabled by defining OH_FIFO_RD_STREAM_STATS_EN.
module oh_fifo_rd_stream #(
  parameter int DW   = 104,
  parameter int SKID = 3
) (
  input  logic                clk,
  input  logic                nreset,
  oh_fifo_rd_stream_if.slave  io
`ifdef OH_FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]         stat_words,
  output logic                stat_stall
`endif
);

  if (SKID != 3) begin : g_skid_check
    $error("oh_fifo_rd_stream: SKID must be 3");
  end

  logic [DW-1:0] r_buf [0:2];
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [1:0]    r_count;
  logic          r_inflight;
  logic          r_discard;

  logic [2:0]    w_pending;
  logic          w_rd_en;
  logic          w_cap;
  logic          w_pop;

  // Modulo-3 pointer increment: 0,1,2,0
  function automatic logic [1:0] f_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already buffered plus the one possibly in flight must leave room
  assign w_pending = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_rd_en   = nreset & ~io.clear & ~io.fifo_empty & (w_pending <= 3'd2);
  assign w_cap     = r_inflight & ~r_discard;
  assign w_pop     = (r_count != 2'd0) & io.out_ready;

  // Occupancy, pointers and in-flight tracking; clear overrides capture and pop
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
    end else if (io.clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= w_rd_en;
      r_discard  <= r_inflight | w_rd_en;
    end else begin
      r_inflight <= w_rd_en;
      r_discard  <= 1'b0;
      if (w_cap) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_cap, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage is data only and carries no reset
  always_ff @(posedge clk) begin
    if (!io.clear && w_cap) r_buf[r_wr_ptr] <= io.fifo_dout;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!nreset)
    !(r_count == 2'd3 && r_inflight));

  assign io.fifo_rd_en = w_rd_en;
  assign io.out_valid  = (r_count != 2'd0);
  assign io.out_data   = r_buf[r_rd_ptr];
  assign io.out_count  = r_count;
  assign io.busy       = (r_count != 2'd0) | r_inflight;

`ifdef OH_FIFO_RD_STREAM_STATS_EN
  logic [31:0] r_stat_words;
  logic [3:0]  r_stall_run;
  logic        r_stat_stall;

  // Accepted-pop counter and sticky 16-cycle stall detector
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_stat_words <= '0;
      r_stall_run  <= '0;
      r_stat_stall <= 1'b0;
    end else begin
      if (w_pop && !io.clear) r_stat_words <= r_stat_words + 32'd1;
      if (io.out_valid && !io.out_ready) begin
        if (r_stall_run == 4'd15) r_stat_stall <= 1'b1;
        else                      r_stall_run  <= r_stall_run + 4'd1;
      end else begin
        r_stall_run <= '0;
      end
    end
  end

  assign stat_words = r_stat_words;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_oh_fifo_rd_stream.sv
// Bench for oh_fifo_rd_stream: a queue-backed FIFO source with one cycle of
// read latency feeds the block; a scoreboard holds every word handed out by
// the source, in order, and is flushed on clear or reset (anything read but
// not yet delivered is lost then). Every accepted pop must match its head.
module tb_oh_fifo_rd_stream;
  localparam int DW = 104;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  oh_fifo_rd_stream_if #(.DW(DW)) io ();

`ifdef OH_FIFO_RD_STREAM_STATS_EN
  logic [31:0] stat_words;
  logic        stat_stall;
`endif

  oh_fifo_rd_stream #(.DW(DW), .SKID(3)) dut (
    .clk    (clk),
    .nreset (nreset),
    .io     (io)
`ifdef OH_FIFO_RD_STREAM_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  // Source FIFO model
  logic [DW-1:0] src_mem [0:255];
  int unsigned   src_wr = 0;
  int unsigned   src_rd = 0;
  logic [DW-1:0] exp_q [$];

  assign io.fifo_empty = (src_wr == src_rd);

  always @(posedge clk) begin
    if (io.fifo_rd_en && (src_wr != src_rd)) begin
      io.fifo_dout <= src_mem[src_rd % 256];
      exp_q.push_back(src_mem[src_rd % 256]);
      src_rd <= src_rd + 1;
    end
  end

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  logic          prev_rd    = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic push(input logic [DW-1:0] v);
    src_mem[src_wr % 256] = v;
    src_wr++;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe mid-cycle with inputs settled, then advance
  task automatic tick();
    #1;
    if (nreset) begin
      chk("valid_vs_count", DW'(io.out_valid), DW'(io.out_count != 2'd0));
      chk("busy", DW'(io.busy), DW'((io.out_count != 2'd0) || prev_rd));
      if (io.fifo_empty || io.clear || (int'(io.out_count) + int'(prev_rd) > 2))
        chk("no_issue", DW'(io.fifo_rd_en), '0);
      if (prev_stall) begin
        chk("hold_valid", DW'(io.out_valid), DW'(1));
        chk("hold_data", io.out_data, prev_data);
      end
      if (io.clear) begin
        exp_q.delete();
      end else if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_pop", DW'(io.out_valid), '0);
        else                   chk("pop_data", io.out_data, exp_q.pop_front());
        n_pop++;
      end
      prev_stall = io.out_valid && !io.out_ready && !io.clear;
      prev_data  = io.out_data;
      prev_rd    = io.fifo_rd_en;
    end else begin
      chk("rst_rd_en", DW'(io.fifo_rd_en), '0);
      chk("rst_valid", DW'(io.out_valid), '0);
      chk("rst_count", DW'(io.out_count), '0);
      chk("rst_busy", DW'(io.busy), '0);
      prev_rd    = 1'b0;
      prev_stall = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] w [0:7];
    int base;
    int k;
    int n_rd;

    io.clear     = 1'b0;
    io.out_ready = 1'b0;

    // Reset with a non-empty FIFO: nothing may be issued
    for (int i = 1; i <= 8; i++) push(DW'(i));
    io.out_ready = 1'b1;
    @(negedge clk);
    repeat (4) tick();
    nreset = 1'b1;

    // Streaming burst: rd_en for 8 cycles, data 1..8 from 2 cycles later
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("burst_rd_en", DW'(io.fifo_rd_en), DW'(c < 8));
      if (c >= 2) begin
        chk("burst_valid", DW'(io.out_valid), DW'(1));
        chk("burst_data", io.out_data, DW'(c - 1));
      end else begin
        chk("burst_lat", DW'(io.out_valid), '0);
      end
      tick();
    end

    // Stalled sink: exactly 3 reads, then drain in order
    io.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    n_rd = 0;
    repeat (6) begin
      #1;
      if (io.fifo_rd_en) n_rd++;
      tick();
    end
    #1;
    chk("stall_reads", DW'(n_rd), DW'(3));
    chk("stall_count", DW'(io.out_count), DW'(3));
    chk("stall_rd_en", DW'(io.fifo_rd_en), '0);
    io.out_ready = 1'b1;
    #1;
    chk("drain_first", io.out_data, DW'(1));
    base = n_pop;
    k = 0;
    while (n_pop < base + 8 && k < 40) begin tick(); k++; end
    chk("drain_all", DW'(n_pop - base), DW'(8));

    // Alternating ready over 20 random words
    for (int i = 0; i < 20; i++) push(DW'({$urandom, $urandom, $urandom, $urandom}));
    base = n_pop;
    k = 0;
    while (n_pop < base + 20 && k < 200) begin
      io.out_ready = (k % 2 == 0);
      tick();
      k++;
    end
    chk("alt_delivered", DW'(n_pop - base), DW'(20));
    chk("alt_leftover", DW'(exp_q.size()), '0);

    // Clear with two buffered words and one in flight
    io.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w[i] = DW'({$urandom, $urandom, $urandom, $urandom});
      push(w[i]);
    end
    k = 0;
    while (k < 20) begin
      #1;
      if (io.out_count == 2'd2) break;
      tick();
      k++;
    end
    chk("pre_clear_count", DW'(io.out_count), DW'(2));
    io.clear = 1'b1;
    #1;
    chk("clear_rd_en", DW'(io.fifo_rd_en), '0);
    tick();
    io.clear = 1'b0;
    #1;
    chk("clear_count", DW'(io.out_count), '0);
    io.out_ready = 1'b1;
    k = 0;
    while (k < 20) begin
      #1;
      if (io.out_valid) break;
      tick();
      k++;
    end
    chk("after_clear_word", io.out_data, w[3]);
    k = 0;
    while ((!io.fifo_empty || io.busy) && k < 40) begin tick(); k++; end
    chk("clear_drain_busy", DW'(io.busy), '0);
    chk("clear_drain_left", DW'(exp_q.size()), '0);

`ifdef OH_FIFO_RD_STREAM_STATS_EN
    // Statistics: 10 accepted words, then a 16-cycle stall
    nreset = 1'b0;
    exp_q.delete();
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 13; i++) push(DW'(32'h100 + i));
    io.out_ready = 1'b1;
    base = n_pop;
    k = 0;
    while (n_pop < base + 10 && k < 40) begin tick(); k++; end
    io.out_ready = 1'b0;
    repeat (15) tick();
    #1;
    chk("stall_not_yet", DW'(stat_stall), '0);
    chk("stat_words", DW'(stat_words), DW'(10));
    tick();
    #1;
    chk("stall_set", DW'(stat_stall), DW'(1));
    io.clear = 1'b1;
    tick();
    io.clear = 1'b0;
    #1;
    chk("stall_sticky", DW'(stat_stall), DW'(1));
    chk("words_kept", DW'(stat_words), DW'(10));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
